// File: rtl/aes_ctrl_pkg.sv
// Shared control types for the AES-128 core front end: arbiter state encoding
// and requester/watchdog sizing, also used by the core start/done wrapper.
// Pure declarations, no logic.
package aes_ctrl_pkg;

  // Largest requester count the arbiter supports (grant index fits in 2 bits).
  localparam int NREQ_MAX = 4;

  // Default BUSY watchdog limit in cycles (only used when AES_WATCHDOG_EN is defined).
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/aes_job_arbiter_rr_picker.sv
// Purpose: round-robin pick of the first valid requester at or above rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is accepted.
module rr_picker
  import aes_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any,
  output logic [IW-1:0]   g
);

  // Doubling the request vector lets a plain right shift act as a rotate.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                sum;

  assign dbl = {req_valid, req_valid};

  // Rotate so rr_ptr sits at bit 0, then take the lowest set bit; scanning
  // downward lets the lowest offset win, and the offset maps back modulo NREQ.
  always_comb begin
    rot = NREQ'(dbl >> rr_ptr);
    any = |rot;
    g   = '0;
    sum = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(rr_ptr) + k;
        if (sum >= NREQ) begin
          sum = sum - NREQ;
        end
        g = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Purpose: shares one AES-128 core among NREQ requesters, round-robin, one job at a time.
// Latency: accept at N -> core_start at N+1; core_done at M -> resp_valid at M+1.
// Backpressure: no accept while a job is in flight; resp_valid holds until resp_ready.
// Optional feature: define AES_WATCHDOG_EN for a BUSY timeout that returns resp_err=1.
module aes_job_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_encrypt,
  input  logic [NREQ-1:0]          req_new_key,
  output logic [NREQ-1:0]          req_ready,
  output logic [$clog2(NREQ)-1:0]  grant_idx,
  output logic                     busy,
  output logic                     core_start,
  output logic                     core_sel_cypher,
  output logic                     core_key_change,
  input  logic                     core_done,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready
`ifdef AES_WATCHDOG_EN
  ,
  output logic                     resp_err
`endif
);

  localparam int IW = $clog2(NREQ);

  // Reject configurations the grant encoding or watchdog cannot represent.
  if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("aes_job_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES at least 2");
  end

  arb_state_t       state;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rr_next;
  logic             key_valid;
  logic [IW-1:0]    key_owner;

  logic             pick_any;
  logic [IW-1:0]    pick_g;
  logic [NREQ-1:0]  pick_oh;
  logic [NREQ-1:0]  gnt_oh;
  logic             enc_sel;
  logic             nk_sel;
  logic             resp_hs;

`ifdef AES_WATCHDOG_EN
  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]             wd_cnt;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .g         (pick_g)
  );

  assign pick_oh   = NREQ'(1) << pick_g;
  assign gnt_oh    = NREQ'(1) << gnt;
  assign enc_sel   = |(req_encrypt & pick_oh);
  assign nk_sel    = |(req_new_key & pick_oh);
  assign resp_hs   = |(resp_ready & gnt_oh);
  assign grant_idx = gnt;

  // Accept strobe is offered only in IDLE, to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick_any) begin
      req_ready = pick_oh;
    end
  end

  // Next rotation start: one past the requester just served, wrapping.
  always_comb begin
    rr_next = '0;
    if (int'(gnt) != NREQ - 1) begin
      rr_next = gnt + 1'b1;
    end
  end

  // Job FSM: accept, issue a one-cycle start, wait for the core, hold the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      gnt             <= '0;
      rr_ptr          <= '0;
      key_valid       <= 1'b0;
      key_owner       <= '0;
      busy            <= 1'b0;
      core_start      <= 1'b0;
      core_sel_cypher <= 1'b0;
      core_key_change <= 1'b0;
      resp_valid      <= '0;
`ifdef AES_WATCHDOG_EN
      wd_cnt          <= '0;
      resp_err        <= 1'b0;
`endif
    end else begin
      // Start and its qualifiers live for the single ISSUE cycle only.
      core_start      <= 1'b0;
      core_sel_cypher <= 1'b0;
      core_key_change <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt             <= pick_g;
            busy            <= 1'b1;
            core_start      <= 1'b1;
            core_sel_cypher <= enc_sel;
            // Re-expand whenever the expanded key might not belong to this requester.
            core_key_change <= nk_sel | ~key_valid | (key_owner != pick_g);
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          key_valid <= 1'b1;
          key_owner <= gnt;
`ifdef AES_WATCHDOG_EN
          wd_cnt    <= '0;
`endif
          state     <= BUSY;
        end
        BUSY: begin
          if (core_done) begin
            resp_valid <= gnt_oh;
`ifdef AES_WATCHDOG_EN
            resp_err   <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef AES_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            // The core state is unknown after a hang, so its key is no longer trusted.
            resp_valid <= gnt_oh;
            resp_err   <= 1'b1;
            key_valid  <= 1'b0;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_hs) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            rr_ptr     <= rr_next;
`ifdef AES_WATCHDOG_EN
            resp_err   <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter with NREQ=2: table of jobs with hand-derived grants
// and key-change expectations, a queue scoreboard from accept to start/response,
// plus hand sequences for mid-job reset, stray core_done and (optionally) watchdog.
module tb_aes_job_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 8;

  logic            clk;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_encrypt;
  logic [NREQ-1:0] req_new_key;
  logic [NREQ-1:0] req_ready;
  logic [0:0]      grant_idx;
  logic            busy;
  logic            core_start;
  logic            core_sel_cypher;
  logic            core_key_change;
  logic            core_done;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
`ifdef AES_WATCHDOG_EN
  logic            resp_err;
`endif

  aes_job_arbiter #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_encrypt     (req_encrypt),
    .req_new_key     (req_new_key),
    .req_ready       (req_ready),
    .grant_idx       (grant_idx),
    .busy            (busy),
    .core_start      (core_start),
    .core_sel_cypher (core_sel_cypher),
    .core_key_change (core_key_change),
    .core_done       (core_done),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready)
`ifdef AES_WATCHDOG_EN
    ,
    .resp_err        (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vld;
    logic [1:0] enc;
    logic [1:0] nk;
    int         dly;
    int         hold;
    int         g;
    logic       e;
    logic       kc;
  } vec_t;

  typedef struct {
    int   g;
    logic e;
    logic kc;
  } exp_t;

  exp_t sb_q[$];
  int   rq[$];
  int   n_chk;
  int   n_err;
  vec_t vecs[11];

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {req_ready, grant_idx, busy, core_start, core_sel_cypher,
             core_key_change, resp_valid}, 32'h0);
  endtask

  // Offer one job, then follow it through start, core completion and response.
  task automatic run_job(input vec_t v);
    exp_t e;
    req_valid   = v.vld;
    req_encrypt = v.enc;
    req_new_key = v.nk;
    #1;
    chk("req_ready_pick", req_ready, oh(v.g));
    e.g  = v.g;
    e.e  = v.e;
    e.kc = v.kc;
    sb_q.push_back(e);
    @(negedge clk);
    chk("core_start", core_start, 1);
    chk("req_ready_issue", req_ready, 0);
    chk("busy_issue", busy, 1);
    if (sb_q.size() == 0) begin
      chk("sb_empty_start", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("grant_idx", grant_idx, e.g);
      chk("sel_cypher", core_sel_cypher, e.e);
      chk("key_change", core_key_change, e.kc);
      rq.push_back(e.g);
    end
    repeat (v.dly) begin
      @(negedge clk);
      chk("busy_wait", {core_start, resp_valid, req_ready}, 0);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    if (rq.size() == 0) begin
      chk("sb_empty_resp", 1, 0);
    end else begin
      chk("resp_valid", resp_valid, oh(rq.pop_front()));
    end
`ifdef AES_WATCHDOG_EN
    chk("resp_err_ok", resp_err, 0);
`endif
    repeat (v.hold) begin
      @(negedge clk);
      chk("resp_hold", resp_valid, oh(v.g));
      chk("no_accept_resp", req_ready, 0);
    end
    resp_ready = oh(v.g);
    @(negedge clk);
    resp_ready = '0;
    chk("resp_clear", resp_valid, 0);
    chk("busy_clear", busy, 0);
    chk("grant_stable", grant_idx, v.g);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vx;
    n_chk = 0;
    n_err = 0;
    //             vld    enc    nk    dly hold g  e     kc
    vecs[0]  = '{2'b01, 2'b01, 2'b00, 1, 0, 0, 1'b1, 1'b1};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 3, 0, 0, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 2'b00, 2, 0, 1, 1'b1, 1'b1};
    vecs[3]  = '{2'b11, 2'b10, 2'b00, 1, 0, 0, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 2'b01, 2'b00, 4, 0, 1, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 2'b00, 1, 0, 0, 1'b1, 1'b1};
    vecs[6]  = '{2'b01, 2'b01, 2'b01, 2, 0, 0, 1'b1, 1'b1};
    vecs[7]  = '{2'b10, 2'b10, 2'b00, 6, 5, 1, 1'b1, 1'b1};
    vecs[8]  = '{2'b11, 2'b00, 2'b10, 1, 0, 0, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 2'b00, 2'b00, 1, 0, 1, 1'b0, 1'b1};
    vecs[10] = '{2'b10, 2'b10, 2'b00, 2, 0, 1, 1'b1, 1'b0};

    reset_n     = 1'b0;
    req_valid   = '0;
    req_encrypt = '0;
    req_new_key = '0;
    resp_ready  = '0;
    core_done   = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    // Stray core_done while idle must not start anything.
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    chk_all_zero("done_in_idle");

    foreach (vecs[i]) begin
      run_job(vecs[i]);
    end

    // Reset asserted while the core is busy on requester 1 (current key owner).
    req_valid   = 2'b10;
    req_encrypt = 2'b00;
    req_new_key = 2'b00;
    #1;
    chk("rst_job_pick", req_ready, 2'b10);
    @(negedge clk);
    chk("rst_job_start", core_start, 1);
    chk("rst_job_kc", core_key_change, 0);
    req_valid = '0;
    @(negedge clk);
    chk("rst_job_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset_busy");
    @(negedge clk);
    reset_n = 1'b1;
    vx = '{2'b10, 2'b10, 2'b00, 2, 0, 1, 1'b1, 1'b1};
    run_job(vx);

`ifdef AES_WATCHDOG_EN
    // Core never answers: timeout after TO BUSY cycles, then the key is reloaded.
    req_valid   = 2'b01;
    req_encrypt = 2'b01;
    req_new_key = 2'b00;
    #1;
    chk("wd_pick", req_ready, 2'b01);
    @(negedge clk);
    chk("wd_start", core_start, 1);
    chk("wd_kc", core_key_change, 1);
    req_valid = '0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("wd_wait", resp_valid, 0);
    end
    @(negedge clk);
    chk("wd_resp", resp_valid, 2'b01);
    chk("wd_err", resp_err, 1);
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    chk("wd_resp_clear", resp_valid, 0);
    vx = '{2'b01, 2'b00, 2'b00, 1, 0, 0, 1'b0, 1'b1};
    run_job(vx);
`endif

    chk("sb_drained", sb_q.size() + rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
